// File: rtl/cache_mem_bridge.sv
// Bridges 128-bit cache line fills/write-backs onto a narrow BUS_W-wide memory bus.
// Define CACHE_BRIDGE_PERF_EN to add saturating fill, write-back and stall counters.
module cache_mem_bridge #(
   parameter int BUS_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_req_valid,
   input  logic              mem_req_rw,
   input  logic [31:0]       mem_req_addr,
   input  logic [127:0]      mem_req_data,
   output logic              mem_resp_ready,
   output logic [127:0]      mem_resp_data,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_we,
   output logic [31:0]       bus_addr,
   output logic [BUS_W-1:0]  bus_wdata,
   input  logic              bus_rdata_valid,
   input  logic [BUS_W-1:0]  bus_rdata
`ifdef CACHE_BRIDGE_PERF_EN
   ,
   output logic [31:0]       perf_fills,
   output logic [31:0]       perf_wbacks,
   output logic [31:0]       perf_stall
`endif
);

   localparam int BEATS = 128 / BUS_W;
   localparam int CW    = $clog2(BEATS + 1);
   localparam int STEP  = BUS_W / 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]       r_state;
   logic [27:0]      r_line;
   logic [127:0]     r_wline;
   logic [127:0]     r_rline;
   logic [CW-1:0]    r_ic;
   logic [CW-1:0]    r_rc;

   logic             w_capture;
   logic             w_issue;
   logic             w_accept;
   logic             w_ret;
   logic             w_last_wr;
   logic             w_last_rd;
   logic [3:0]       w_off;
   logic [BUS_W-1:0] w_wbeat;
   logic             w_unused;

   assign w_unused  = ^mem_req_addr[3:0];
   assign w_capture = mem_req_valid && ((r_state == S_IDLE) || (r_state == S_RESP));
   assign w_issue   = ((r_state == S_WRITE) || (r_state == S_READ)) && (r_ic != CW'(BEATS));
   assign w_accept  = w_issue && bus_req_ready;
   // A returning beat only counts while one is outstanding, so stray data after reset is dropped.
   assign w_ret     = (r_state == S_READ) && bus_rdata_valid && (r_rc != r_ic);
   assign w_last_wr = (r_state == S_WRITE) && w_accept && (r_ic == CW'(BEATS - 1));
   assign w_last_rd = w_ret && (r_rc == CW'(BEATS - 1));

   always_comb begin
      w_off   = 4'd0;
      w_wbeat = '0;
      for (int i = 0; i < BEATS; i++) begin
         if (r_ic == CW'(i)) begin
            w_off   = 4'(i * STEP);
            w_wbeat = r_wline[i*BUS_W +: BUS_W];
         end
      end
   end

   // Beat offset never carries into the line address bits.
   assign bus_req_valid  = w_issue;
   assign bus_we         = w_issue && (r_state == S_WRITE);
   assign bus_addr       = w_issue ? {r_line, w_off} : 32'd0;
   assign bus_wdata      = bus_we ? w_wbeat : '0;
   assign mem_resp_ready = (r_state == S_RESP);
   assign mem_resp_data  = r_rline;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_ic    <= '0;
         r_rc    <= '0;
         r_line  <= '0;
         r_wline <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_RESP: begin
               if (w_capture) begin
                  r_state <= mem_req_rw ? S_WRITE : S_READ;
                  r_line  <= mem_req_addr[31:4];
                  r_wline <= mem_req_data;
                  r_ic    <= '0;
                  r_rc    <= '0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WRITE: begin
               if (w_accept)  r_ic    <= r_ic + CW'(1);
               if (w_last_wr) r_state <= S_RESP;
            end
            S_READ: begin
               if (w_accept)  r_ic    <= r_ic + CW'(1);
               if (w_ret)     r_rc    <= r_rc + CW'(1);
               if (w_last_rd) r_state <= S_RESP;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rline <= '0;
      end else if (w_ret) begin
         for (int i = 0; i < BEATS; i++) begin
            if (r_rc == CW'(i)) r_rline[i*BUS_W +: BUS_W] <= bus_rdata;
         end
      end
   end

`ifdef CACHE_BRIDGE_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] r_fills;
   logic [31:0] r_wbacks;
   logic [31:0] r_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fills  <= '0;
         r_wbacks <= '0;
         r_stall  <= '0;
      end else begin
         if (w_last_rd)                r_fills  <= sat_inc(r_fills);
         if (w_last_wr)                r_wbacks <= sat_inc(r_wbacks);
         if (w_issue && !bus_req_ready) r_stall <= sat_inc(r_stall);
      end
   end

   assign perf_fills  = r_fills;
   assign perf_wbacks = r_wbacks;
   assign perf_stall  = r_stall;
`endif

endmodule

// File: doc/cache_mem_bridge.md
Name: cache_mem_bridge

Overview:
- Memory-side stage directly downstream of the direct-mapped cache controller.
- Accepts 128-bit line requests (line fill or dirty write-back) and turns each into a burst of BUS_W-wide beats on the narrow external memory bus.
- Assembles read beats into one 128-bit line and returns it with a one-cycle ready pulse.

Parameters:
- BUS_W, 32: external data width in bits; legal values 32, 64, 128.
- BEATS = 128/BUS_W: derived, not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- mem_req_valid  in  1  line request strobe from cache controller
- mem_req_rw  in  1  1 = write-back, 0 = fill
- mem_req_addr  in  32  byte address; bits [3:0] ignored
- mem_req_data  in  128  write-back line
- mem_resp_ready  out  1  one-cycle completion pulse
- mem_resp_data  out  128  filled line, valid while mem_resp_ready
- bus_req_valid  out  1  beat request valid
- bus_req_ready  in  1  bus accepts beat
- bus_we  out  1  beat is write
- bus_addr  out  32  beat byte address
- bus_wdata  out  BUS_W  write beat data
- bus_rdata_valid  in  1  read beat returning, in order
- bus_rdata  in  BUS_W  read beat data

Behaviour:
- Reset (reset low, async): state IDLE, counters 0. Outputs mem_resp_ready=0, mem_resp_data=0, bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0.
- Request capture: in IDLE or RESP, mem_req_valid=1 latches rw, line address {addr[31:4],4'b0} and data. The request may be a single-cycle pulse; the bridge holds its own copy. mem_req_valid in any other state is ignored.
- States: IDLE, WRITE, READ, RESP.
  - Captured rw=1 -> WRITE. Captured rw=0 -> READ.
- WRITE:
  - Issues BEATS beats: bus_we=1, bus_addr = line + i*(BUS_W/8), bus_wdata = line bits [i*BUS_W +: BUS_W], with i from 0 to BEATS-1.
  - Beat i completes on the cycle bus_req_valid & bus_req_ready.
  - Writes are posted. After the last beat is accepted -> RESP.
- READ:
  - Issue counter ic steps through the beats with bus_we=0 and the same address sequence.
  - A separate return counter rc places bus_rdata into mem_resp_data slice rc on each bus_rdata_valid.
  - Issue and return may overlap; ic may lead rc by up to BEATS.
  - bus_rdata_valid with no outstanding beat (rc == ic) is ignored.
  - rc reaching BEATS -> RESP.
- RESP:
  - mem_resp_ready=1 for exactly one cycle, then IDLE.
  - A new mem_req_valid in the RESP cycle is captured; this supports the controller's back-to-back write-back-then-fill. The next state is then WRITE or READ directly.
- Handshake rules:
  - bus_req_valid stays high, with stable bus_addr, bus_we and bus_wdata, until accepted.
  - bus_req_valid never deasserts before acceptance.
  - bus_req_valid=0 outside WRITE/READ, and in READ once ic == BEATS.
- Latency:
  - Write with bus_req_ready held at 1: capture, BEATS issue cycles, 1 RESP cycle.
  - Read with bus_req_ready=1 and rdata one cycle after acceptance: BEATS+2 cycles from capture to mem_resp_ready.
- Address: byte address. Increment stays inside the 16-byte line and does not carry into bits [31:4].
- mem_resp_data holds its value after RESP until the next fill overwrites it.
- Reset mid-burst: immediate return to IDLE and counters cleared. Late bus_rdata_valid after reset is ignored, since rc == ic == 0.

Optional Feature:
- CACHE_BRIDGE_PERF_EN defined adds three outputs:
  - perf_fills (32): completed READ bursts.
  - perf_wbacks (32): completed WRITE bursts.
  - perf_stall (32): cycles with bus_req_valid=1 and bus_req_ready=0.
- Each counter saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: the ports are absent and no counter logic is generated.

Test Plan:
- Fill, BUS_W=32:
  - Stimulus: mem_req_valid pulse, rw=0, addr=32'h0001_2344; bus_req_ready=1; rdata returned one cycle after acceptance as 11111111, 22222222, 33333333, 44444444.
  - Response: bus_addr sequence 12340, 12344, 12348, 1234C. One mem_resp_ready pulse with mem_resp_data=128'h44444444_33333333_22222222_11111111.
- Write-back:
  - Stimulus: rw=1, addr=32'h0000_0080, data=128'hDDDD..._AAAA...; bus_req_ready low for 2 cycles on beat 1.
  - Response: bus_addr/bus_wdata hold stable during the stall. Beats at 80, 84, 88, 8C carry AAAA..., BBBB..., CCCC..., DDDD... in that order; mem_resp_ready pulses once.
- Back-to-back:
  - Stimulus: write-back to 0x80, then fill to 0x40 pulsed in the RESP cycle.
  - Response: fill captured with no idle cycle; the first read beat to 0x40 is on the cycle after RESP.
- Ignored inputs:
  - Stimulus: mem_req_valid during READ, and a spurious bus_rdata_valid in IDLE.
  - Response: no new burst, mem_resp_data unchanged, no mem_resp_ready.
- Reset mid-read:
  - Stimulus: reset low after 2 of 4 beats issued, then 2 late rdata beats after release.
  - Response: all outputs 0 and state IDLE. A following fill to 0x100 completes normally with correct data.
- PERF:
  - Stimulus: with CACHE_BRIDGE_PERF_EN, one fill, two write-backs, 5 stall cycles.
  - Response: perf_fills=1, perf_wbacks=2, perf_stall=5.
